// File: rtl/falafel_pkg.sv
// Shared types for the falafel allocator request path: op/state enums,
// the latched core request record and the data word width.
package falafel_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } req_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } arb_state_e;

    typedef struct packed {
        req_op_e op;
        word_t   data;
    } core_req_t;

    function automatic req_op_e other_op(input req_op_e op);
        return (op == OP_ALLOC) ? OP_FREE : OP_ALLOC;
    endfunction

endpackage

// File: rtl/falafel_rr_arbiter2.sv
// Two-way alloc/free grant logic with a last-grant register.
// Define FALAFEL_ARB_FREE_PRIO_EN to give free requests strict priority.
module falafel_rr_arbiter2
    import falafel_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    alloc_req_i,
    input  logic    free_req_i,
    input  logic    gnt_en_i,
    output logic    gnt_valid_o,
    output req_op_e gnt_op_o
);

    req_op_e last_grant_q;
    req_op_e last_grant_d;

    always_comb begin
        gnt_valid_o = alloc_req_i || free_req_i;
`ifdef FALAFEL_ARB_FREE_PRIO_EN
        gnt_op_o = free_req_i ? OP_FREE : OP_ALLOC;
`else
        if (alloc_req_i && free_req_i) begin
            gnt_op_o = other_op(last_grant_q);
        end else if (free_req_i) begin
            gnt_op_o = OP_FREE;
        end else begin
            gnt_op_o = OP_ALLOC;
        end
`endif
        last_grant_d = (gnt_en_i && gnt_valid_o) ? gnt_op_o : last_grant_q;
    end

    // Reset to FREE so the first contended grant goes to alloc.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= OP_FREE;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/falafel_req_arbiter.sv
// Pops alloc/free requests one at a time and hands them to the allocator
// core over valid/ready, then waits for done. Macro: FALAFEL_ARB_FREE_PRIO_EN.
module falafel_req_arbiter
    import falafel_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_fifo_empty_i,
    output logic              alloc_fifo_read_o,
    input  logic [DATA_W-1:0] alloc_fifo_dout_i,
    input  logic              free_fifo_empty_i,
    output logic              free_fifo_read_o,
    input  logic [DATA_W-1:0] free_fifo_dout_i,
    output logic              core_req_val_o,
    input  logic              core_req_rdy_i,
    output logic              core_req_op_o,
    output logic [DATA_W-1:0] core_req_data_o,
    input  logic              core_done_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  alloc_cnt_o,
    output logic [CNT_W-1:0]  free_cnt_o
);

    arb_state_e       state_q, state_d;
    core_req_t        req_q, req_d;
    logic             val_q, val_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;

    logic    pop_en;
    logic    pop;
    logic    gnt_valid;
    req_op_e gnt_op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Strobes are combinational, so gate them with reset to keep them low
    // while rst_ni is held.
    assign pop_en = rst_ni && (state_q == IDLE);
    assign pop    = pop_en && gnt_valid;

    falafel_rr_arbiter2 u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_req_i (!alloc_fifo_empty_i),
        .free_req_i  (!free_fifo_empty_i),
        .gnt_en_i    (pop_en),
        .gnt_valid_o (gnt_valid),
        .gnt_op_o    (gnt_op)
    );

    assign alloc_fifo_read_o = pop && (gnt_op == OP_ALLOC);
    assign free_fifo_read_o  = pop && (gnt_op == OP_FREE);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        val_d       = val_q;
        alloc_cnt_d = alloc_cnt_q;
        free_cnt_d  = free_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    req_d.op   = gnt_op;
                    req_d.data = (gnt_op == OP_FREE) ? free_fifo_dout_i : alloc_fifo_dout_i;
                    if (gnt_op == OP_FREE) begin
                        free_cnt_d = sat_inc(free_cnt_q);
                    end else begin
                        alloc_cnt_d = sat_inc(alloc_cnt_q);
                    end
                    val_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (core_req_rdy_i) begin
                    val_d   = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                val_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_q       <= '{op: OP_ALLOC, data: '0};
            val_q       <= 1'b0;
            busy_q      <= 1'b0;
            alloc_cnt_q <= '0;
            free_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            val_q       <= val_d;
            busy_q      <= busy_d;
            alloc_cnt_q <= alloc_cnt_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    assign core_req_val_o  = val_q;
    assign core_req_op_o   = req_q.op;
    assign core_req_data_o = req_q.data;
    assign busy_o          = busy_q;
    assign alloc_cnt_o     = alloc_cnt_q;
    assign free_cnt_o      = free_cnt_q;

endmodule
